fetch_unit: RTL and testbench

//  Instruction fetch stage, directly upstream of decode_execute. Owns the architectural PC,

---
 rtl/fetch_unit.sv | 198 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Owns the architectural PC and fetches one instruction at a time over a
// req/gnt/rvalid memory port. The fetched word is presented to
// decode_execute as ir/pc. When decode_execute consumes the instruction,
// the next PC is chosen from its pc_sel/imm/br_taken/rs1_data inputs.
// Only one instruction is ever in flight, so a branch never needs a flush.
// A computed target that is not 4-byte aligned parks the unit in a halt
// state that only reset can leave.

`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 3
`endif
`ifndef SEL_PC_PLUS4
`define SEL_PC_PLUS4 3'd0
`endif
`ifndef SEL_PC_JAL
`define SEL_PC_JAL 3'd1
`endif
`ifndef SEL_PC_JALR
`define SEL_PC_JALR 3'd2
`endif
`ifndef SEL_PC_BRANCH
`define SEL_PC_BRANCH 3'd3
`endif

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // instruction memory port
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    // interface to decode_execute
    output logic [31:0]              ir,
    output logic [31:0]              pc,
    output logic                     ir_valid,
    input  logic                     ex_ready,
    input  logic [`SEL_PC_WIDTH-1:0] pc_sel,
    input  logic [31:0]              imm,
    input  logic                     br_taken,
    input  logic [31:0]              rs1_data,
    // status
    output logic                     fetch_misaligned,
    output logic [31:0]              fetch_count
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Next-PC selection. Every addition wraps at 32 bits.
    // A JALR target always has bit 0 cleared.
    // Any unused select code falls back to sequential fetch.
    function automatic logic [31:0] calc_next_pc(
        input logic [`SEL_PC_WIDTH-1:0] sel,
        input logic [31:0]              pc_v,
        input logic [31:0]              imm_v,
        input logic [31:0]              rs1_v,
        input logic                     taken
    );
        logic [31:0] result;
        case (sel)
            `SEL_PC_PLUS4:  result = pc_v + 32'd4;
            `SEL_PC_JAL:    result = pc_v + imm_v;
            `SEL_PC_JALR:   result = (rs1_v + imm_v) & ~32'h0000_0001;
            `SEL_PC_BRANCH: result = taken ? (pc_v + imm_v) : (pc_v + 32'd4);
            default:        result = pc_v + 32'd4;
        endcase
        return result;
    endfunction

    // A word-aligned address has both low bits clear.
    function automatic logic is_misaligned(input logic [31:0] addr_v);
        return (addr_v[1:0] != 2'b00);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] count_q, count_d;
    logic        imem_req_q, imem_req_d;
    logic        ir_valid_q, ir_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] next_pc_s;
    logic        consume_s;

    // Candidate next PC. It is only committed when the held instruction
    // is consumed.
    always_comb begin
        next_pc_s = calc_next_pc(pc_sel, pc_q, imm, rs1_data, br_taken);
    end

    // ex_ready only has an effect while a valid instruction is held.
    always_comb begin
        consume_s = (state_q == S_VALID) && ex_ready;
    end

    // FSM next-state logic, plus the PC, IR and counter datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        count_d = count_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A stray rvalid left over from before a reset is ignored here.
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    state_d = S_VALID;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_VALID: begin
                if (consume_s) begin
                    // The PC takes the target even when that target faults,
                    // so the bad address stays visible on pc.
                    pc_d    = next_pc_s;
                    ir_d    = NOP_INSN;
                    count_d = count_q + 32'd1;
                    if (is_misaligned(next_pc_s)) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_VALID;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // An encoding outside the enum recovers through a clean boot.
                state_d = S_BOOT;
                ir_d    = NOP_INSN;
            end
        endcase
    end

    // Output flags are decoded from the next state and registered,
    // so the ports never carry combinational glitches.
    always_comb begin
        imem_req_d   = (state_d == S_REQ);
        ir_valid_d   = (state_d == S_VALID);
        misaligned_d = misaligned_q | (state_d == S_HALT);
    end

    // State, datapath and output registers.
    // Asynchronous reset drops any response that is still outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_PC;
            ir_q         <= NOP_INSN;
            count_q      <= 32'd0;
            imem_req_q   <= 1'b0;
            ir_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            count_q      <= count_d;
            imem_req_q   <= imem_req_d;
            ir_valid_q   <= ir_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_req         = imem_req_q;
    assign imem_addr        = pc_q;
    assign ir               = ir_q;
    assign pc               = pc_q;
    assign ir_valid         = ir_valid_q;
    assign fetch_misaligned = misaligned_q;
    assign fetch_count      = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit.
// Memory and decode_execute are both modelled by the bench. Expected
// PC, fetch count and instruction words come from a small arithmetic
// model of the next-PC rules.

`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 3
`endif
`ifndef SEL_PC_PLUS4
`define SEL_PC_PLUS4 3'd0
`endif
`ifndef SEL_PC_JAL
`define SEL_PC_JAL 3'd1
`endif
`ifndef SEL_PC_JALR
`define SEL_PC_JALR 3'd2
`endif
`ifndef SEL_PC_BRANCH
`define SEL_PC_BRANCH 3'd3
`endif

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic                     clk;
    logic                     rst_n;
    logic                     imem_req;
    logic [31:0]              imem_addr;
    logic                     imem_gnt;
    logic                     imem_rvalid;
    logic [31:0]              imem_rdata;
    logic [31:0]              ir;
    logic [31:0]              pc;
    logic                     ir_valid;
    logic                     ex_ready;
    logic [`SEL_PC_WIDTH-1:0] pc_sel;
    logic [31:0]              imm;
    logic                     br_taken;
    logic [31:0]              rs1_data;
    logic                     fetch_misaligned;
    logic [31:0]              fetch_count;

    int          n_checks;
    int          n_fail;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .ir_valid(ir_valid), .ex_ready(ex_ready),
        .pc_sel(pc_sel), .imm(imm), .br_taken(br_taken), .rs1_data(rs1_data),
        .fetch_misaligned(fetch_misaligned), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference next-PC rule.
    function automatic logic [31:0] model_next(input logic [`SEL_PC_WIDTH-1:0] s, input logic [31:0] p,
                                               input logic [31:0] i, input logic [31:0] r, input logic b);
        if (s == `SEL_PC_JAL) return p + i;
        if (s == `SEL_PC_JALR) return (r + i) & 32'hFFFF_FFFE;
        if (s == `SEL_PC_BRANCH && b) return p + i;
        return p + 32'd4;
    endfunction

    task automatic randomize_ex_side();
        pc_sel   = `SEL_PC_WIDTH'($urandom_range(0, 7));
        imm      = $urandom;
        br_taken = 1'($urandom_range(0, 1));
        rs1_data = $urandom;
    endtask

    // One complete fetch/consume transaction.
    // gd : cycles that gnt is held low.
    // rd : idle cycles between gnt and rvalid.
    // ed : cycles that ex_ready is held low.
    task automatic run_insn(input int gd, input int rd, input int ed,
                            input logic [`SEL_PC_WIDTH-1:0] sel, input logic [31:0] imm_v,
                            input logic [31:0] rs1_v, input logic br_v);
        logic [31:0] word;
        logic [31:0] exp_next;
        int waited;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_timeout: got %b expected 1", imem_req);
        end
        n_checks++;
        if (imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL imem_addr: got %h expected %h", imem_addr, m_pc);
        end
        // Grant stall: a stray rvalid and ex_ready must both be ignored.
        for (int i = 0; i < gd; i++) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            ex_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if ({imem_req, imem_addr, ir_valid, ir} !== {1'b1, m_pc, 1'b0, NOP}) begin
                n_fail++;
                $display("FAIL req_stall: got req=%b addr=%h v=%b ir=%h expected req=1 addr=%h v=0 ir=%h",
                         imem_req, imem_addr, ir_valid, ir, m_pc, NOP);
            end
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        ex_ready    = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_gnt = 1'b0;
        n_checks++;
        if ({imem_req, ir_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_state: got req=%b valid=%b expected 0 0", imem_req, ir_valid);
        end
        for (int i = 0; i < rd; i++) begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            ex_ready    = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if ({imem_req, ir_valid, ir} !== {1'b0, 1'b0, NOP}) begin
                n_fail++;
                $display("FAIL wait_stall: got req=%b v=%b ir=%h expected 0 0 %h", imem_req, ir_valid, ir, NOP);
            end
        end
        word        = $urandom;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        ex_ready    = 1'($urandom_range(0, 1));
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        n_checks++;
        if ({ir_valid, ir, pc, imem_req} !== {1'b1, word, m_pc, 1'b0}) begin
            n_fail++;
            $display("FAIL valid_insn: got v=%b ir=%h pc=%h req=%b expected 1 %h %h 0",
                     ir_valid, ir, pc, imem_req, word, m_pc);
        end
        // ex_ready stall: ir/pc/count must hold steady.
        for (int i = 0; i < ed; i++) begin
            ex_ready = 1'b0;
            randomize_ex_side();
            @(negedge clk);
            n_checks++;
            if ({ir_valid, ir, pc, fetch_count} !== {1'b1, word, m_pc, m_cnt}) begin
                n_fail++;
                $display("FAIL ex_stall: got v=%b ir=%h pc=%h cnt=%0d expected 1 %h %h %0d",
                         ir_valid, ir, pc, fetch_count, word, m_pc, m_cnt);
            end
        end
        ex_ready = 1'b1;
        pc_sel   = sel;
        imm      = imm_v;
        rs1_data = rs1_v;
        br_taken = br_v;
        exp_next = model_next(sel, m_pc, imm_v, rs1_v, br_v);
        @(negedge clk);
        ex_ready = 1'b0;
        randomize_ex_side();
        m_pc  = exp_next;
        m_cnt = m_cnt + 32'd1;
        n_checks++;
        if ({pc, fetch_count, ir, ir_valid} !== {m_pc, m_cnt, NOP, 1'b0}) begin
            n_fail++;
            $display("FAIL consume: got pc=%h cnt=%0d ir=%h v=%b expected %h %0d %h 0",
                     pc, fetch_count, ir, ir_valid, m_pc, m_cnt, NOP);
        end
        n_checks++;
        if (m_pc[1:0] != 2'b00) begin
            if ({fetch_misaligned, imem_req} !== 2'b10) begin
                n_fail++;
                $display("FAIL halt_entry: got mis=%b req=%b expected 1 0", fetch_misaligned, imem_req);
            end
        end else begin
            if ({fetch_misaligned, imem_req, imem_addr} !== {1'b0, 1'b1, m_pc}) begin
                n_fail++;
                $display("FAIL next_req: got mis=%b req=%b addr=%h expected 0 1 %h",
                         fetch_misaligned, imem_req, imem_addr, m_pc);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        ex_ready    = 1'b0;
        m_pc        = RESET_PC;
        m_cnt       = 32'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({imem_req, imem_addr, ir, pc, ir_valid, fetch_misaligned, fetch_count} !==
            {1'b0, RESET_PC, NOP, RESET_PC, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b addr=%h ir=%h pc=%h v=%b mis=%b cnt=%0d",
                     imem_req, imem_addr, ir, pc, ir_valid, fetch_misaligned, fetch_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) run_insn(0, 0, 0, `SEL_PC_PLUS4, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if ({fetch_count, pc} !== {32'd3, 32'h0000_000C}) begin
            n_fail++;
            $display("FAIL seq_count: got cnt=%0d pc=%h expected 3 0000000c", fetch_count, pc);
        end
    endtask

    task automatic test_branch();
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'h0000_0100 - m_pc, 32'd0, 1'b0);
        run_insn(0, 0, 0, `SEL_PC_BRANCH, 32'hFFFF_FFF0, 32'd0, 1'b1);
        n_checks++;
        if (imem_addr !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL branch_taken: got %h expected 000000f0", imem_addr);
        end
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'h0000_0010, 32'd0, 1'b0);
        run_insn(0, 0, 0, `SEL_PC_BRANCH, 32'hFFFF_FFF0, 32'd0, 1'b0);
        n_checks++;
        if (imem_addr !== 32'h0000_0104) begin
            n_fail++;
            $display("FAIL branch_not_taken: got %h expected 00000104", imem_addr);
        end
    endtask

    task automatic test_jump();
        run_insn(0, 0, 0, `SEL_PC_JALR, 32'd4, 32'h0000_2001, 1'b0);
        n_checks++;
        if (imem_addr !== 32'h0000_2004) begin
            n_fail++;
            $display("FAIL jalr_target: got %h expected 00002004", imem_addr);
        end
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'h0000_0040 - m_pc, 32'd0, 1'b0);
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'h0000_07FC, 32'd0, 1'b0);
        n_checks++;
        if (imem_addr !== 32'h0000_083C) begin
            n_fail++;
            $display("FAIL jal_target: got %h expected 0000083c", imem_addr);
        end
    endtask

    task automatic test_stalls();
        logic [31:0] cnt0;
        cnt0 = fetch_count;
        run_insn(5, 2, 4, `SEL_PC_PLUS4, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if (fetch_count !== cnt0 + 32'd1) begin
            n_fail++;
            $display("FAIL one_consume: got %0d expected %0d", fetch_count, cnt0 + 32'd1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_insn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     `SEL_PC_WIDTH'($urandom_range(0, 7)), $urandom & 32'hFFFF_FFFC,
                     ($urandom & 32'hFFFF_FFFC) | ($urandom & 32'd1), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_wrap();
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'hFFFF_FFFC - m_pc, 32'd0, 1'b0);
        run_insn(1, 1, 1, `SEL_PC_PLUS4, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if ({imem_addr, fetch_misaligned} !== {32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL pc_wrap: got addr=%h mis=%b expected 00000000 0", imem_addr, fetch_misaligned);
        end
    endtask

    task automatic test_misaligned();
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'h0000_0010 - m_pc, 32'd0, 1'b0);
        run_insn(0, 0, 0, `SEL_PC_JAL, 32'd2, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            ex_ready    = 1'($urandom_range(0, 1));
            randomize_ex_side();
            @(negedge clk);
            n_checks++;
            if ({imem_req, fetch_misaligned, ir_valid, pc, fetch_count} !==
                {1'b0, 1'b1, 1'b0, 32'h0000_0012, m_cnt}) begin
                n_fail++;
                $display("FAIL halt_hold: got req=%b mis=%b v=%b pc=%h cnt=%0d expected 0 1 0 00000012 %0d",
                         imem_req, fetch_misaligned, ir_valid, pc, fetch_count, m_cnt);
            end
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        ex_ready    = 1'b0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        rst_n = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        // Unit is now waiting for read data; reset it before the data arrives.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        imem_rvalid = 1'b0;
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
        n_checks++;
        if ({ir, ir_valid, imem_req, imem_addr, fetch_misaligned} !== {NOP, 1'b0, 1'b1, RESET_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL late_rvalid: got ir=%h v=%b req=%b addr=%h mis=%b expected %h 0 1 %h 0",
                     ir, ir_valid, imem_req, imem_addr, fetch_misaligned, NOP, RESET_PC);
        end
        run_insn(0, 1, 0, `SEL_PC_PLUS4, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        ex_ready    = 1'b0;
        pc_sel      = `SEL_PC_PLUS4;
        imm         = 32'd0;
        br_taken    = 1'b0;
        rs1_data    = 32'd0;
        m_pc        = RESET_PC;
        m_cnt       = 32'd0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stalls();
        test_random();
        test_wrap();
        test_misaligned();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
